// File: rtl/sift_pkg.sv
// Shared constants and state encoding for the SIFT orientation path.
package sift_pkg;
   localparam int ORI_N_BINS = 32;
   localparam int ORI_BIN_W  = 5;
   localparam int ORI_MAG_W  = 8;
   localparam int ORI_ACC_W  = 16;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_SEARCH = 2'd1,
      ST_OUTPUT = 2'd2
   } ori_state_e;
endpackage

// File: rtl/ori_peak_scan.sv
// Sequential arg-max over the histogram: one bin per enabled cycle, ties keep the lower index.
module ori_peak_scan
   import sift_pkg::*;
#(
   parameter int N_BINS = ORI_N_BINS,
   parameter int BIN_W  = ORI_BIN_W,
   parameter int ACC_W  = ORI_ACC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             en,
   input  logic [ACC_W-1:0] cur_val,
   output logic [BIN_W-1:0] idx,
   output logic [BIN_W-1:0] best_bin,
   output logic [ACC_W-1:0] best_val,
   output logic             done
);
   localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(N_BINS - 1);
   localparam logic [BIN_W-1:0] ONE      = BIN_W'(1);

   assign done = en && (idx == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= '0;
         best_bin <= '0;
         best_val <= '0;
      end else if (start) begin
         idx      <= '0;
         best_bin <= '0;
         best_val <= '0;
      end else if (en) begin
         // strict compare: an equal later bin never displaces an earlier one
         if (cur_val > best_val) begin
            best_bin <= idx;
            best_val <= cur_val;
         end
         idx <= idx + ONE;
      end
   end
endmodule

// File: rtl/ori_hist_acc.sv
// Orientation histogram: accumulate saturating magnitudes per bin, scan for the peak, hand it off.
module ori_hist_acc
   import sift_pkg::*;
#(
   parameter int N_BINS = ORI_N_BINS,
   parameter int BIN_W  = ORI_BIN_W,
   parameter int MAG_W  = ORI_MAG_W,
   parameter int ACC_W  = ORI_ACC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BIN_W-1:0] in_bin,
   input  logic [MAG_W-1:0] in_mag,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BIN_W-1:0] out_bin,
   output logic [ACC_W-1:0] out_peak
);
   ori_state_e       state, state_nxt;
   logic [ACC_W-1:0] hist [N_BINS];
   logic             accept, start, done;
   logic [BIN_W-1:0] scan_idx;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] sat;

   assign in_ready  = (state == ST_ACCUM) && !rst;
   assign out_valid = (state == ST_OUTPUT);
   assign accept    = in_valid && in_ready;
   assign start     = accept && in_last;

   // one extra bit catches the carry so the bin clamps instead of wrapping
   assign sum = {1'b0, hist[in_bin]} + {{(ACC_W + 1 - MAG_W){1'b0}}, in_mag};
   assign sat = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_ACCUM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ACCUM:  if (start)     state_nxt = ST_SEARCH;
         ST_SEARCH: if (done)      state_nxt = ST_OUTPUT;
         ST_OUTPUT: if (out_ready) state_nxt = ST_ACCUM;
         default:                  state_nxt = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_BINS; i++) hist[i] <= '0;
      end else if (out_valid && out_ready) begin
         for (int i = 0; i < N_BINS; i++) hist[i] <= '0;
      end else if (accept) begin
         hist[in_bin] <= sat;
      end
   end

   ori_peak_scan #(
      .N_BINS (N_BINS),
      .BIN_W  (BIN_W),
      .ACC_W  (ACC_W)
   ) u_scan (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .en       (state == ST_SEARCH),
      .cur_val  (hist[scan_idx]),
      .idx      (scan_idx),
      .best_bin (out_bin),
      .best_val (out_peak),
      .done     (done)
   );
endmodule

// File: tb/tb_ori_hist_acc.sv
// Directed bench for ori_hist_acc with hand-computed expected peaks.
module tb_ori_hist_acc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_bin = '0;
   logic [7:0]  in_mag = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  out_bin;
   logic [15:0] out_peak;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ori_hist_acc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bin    (in_bin),
      .in_mag    (in_mag),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bin   (out_bin),
      .out_peak  (out_peak)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] b, input logic [7:0] m, input logic l);
      in_valid = 1'b1;
      in_bin   = b;
      in_mag   = m;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // counts edges from the in_last accept until out_valid, bounded
   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hs_out_valid_low", 32'(out_valid), 0);
      chk("hs_in_ready", 32'(in_ready), 1);
   endtask

   initial begin
      int lat;
      logic [4:0]  hb;
      logic [15:0] hp;

      // reset values
      tick();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_bin", 32'(out_bin), 0);
      chk("rst_out_peak", 32'(out_peak), 0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      tick();

      // 1: single sample in a wrap-range bin, check latency
      send(5'h1d, 8'd200, 1'b1);
      chk("t1_in_ready_search", 32'(in_ready), 0);
      wait_result(lat);
      chk("t1_latency", 32'(lat), 32);
      chk("t1_bin", 32'(out_bin), 32'h1d);
      chk("t1_peak", 32'(out_peak), 200);
      handshake();

      // 2: tie resolves to the lower bin
      send(5'd3, 8'd10, 1'b0);
      send(5'd7, 8'd10, 1'b1);
      wait_result(lat);
      chk("t2_latency", 32'(lat), 32);
      chk("t2_bin", 32'(out_bin), 3);
      chk("t2_peak", 32'(out_peak), 10);
      handshake();

      // 3: saturation, 300 x 255 = 76500 clamps to 65535
      for (int i = 0; i < 300; i++) send(5'd5, 8'd255, i == 299);
      wait_result(lat);
      chk("t3_bin", 32'(out_bin), 5);
      chk("t3_peak", 32'(out_peak), 65535);
      handshake();

      // 4: back-to-back same bin, then backpressure
      send(5'd9, 8'd1, 1'b0);
      send(5'd9, 8'd2, 1'b0);
      send(5'd9, 8'd3, 1'b1);
      wait_result(lat);
      chk("t4_bin", 32'(out_bin), 9);
      chk("t4_peak", 32'(out_peak), 6);
      hb = out_bin;
      hp = out_peak;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_hold_valid", 32'(out_valid), 1);
         chk("t4_hold_bin", 32'(out_bin), 32'(hb));
         chk("t4_hold_peak", 32'(out_peak), 32'(hp));
         chk("t4_hold_in_ready", 32'(in_ready), 0);
      end
      handshake();
      send(5'd0, 8'd1, 1'b1);
      wait_result(lat);
      chk("t4b_bin", 32'(out_bin), 0);
      chk("t4b_peak", 32'(out_peak), 1);
      handshake();

      // 5: reset during the scan discards the window
      send(5'd6, 8'd50, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      #1;
      chk("t5_rst_out_valid", 32'(out_valid), 0);
      tick();
      rst = 1'b0;
      #1;
      chk("t5_in_ready", 32'(in_ready), 1);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid) chk("t5_no_result", 32'(out_valid), 0);
      end
      send(5'd2, 8'd4, 1'b1);
      wait_result(lat);
      chk("t5_latency", 32'(lat), 32);
      chk("t5_bin", 32'(out_bin), 2);
      chk("t5_peak", 32'(out_peak), 4);
      handshake();

      // 6: zero-weight window
      send(5'd12, 8'd0, 1'b0);
      send(5'd20, 8'd0, 1'b1);
      wait_result(lat);
      chk("t6_valid", 32'(out_valid), 1);
      chk("t6_bin", 32'(out_bin), 0);
      chk("t6_peak", 32'(out_peak), 0);
      handshake();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
